// File: rtl/inst_wb_bus_if_if.sv
// Wishbone B4 classic bus bundle between the instruction fetch master and the
// shared interconnect.
//   master modport: drives adr/dat_o/we/sel/stb/cyc, samples dat_i/ack.
//   slave  modport: the reverse, for the interconnect or a bench slave.
interface inst_wb_bus_if_if;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/inst_wb_bus_if.sv
// Instruction-fetch Wishbone classic master. Turns each fetch request from
// pc_reg into a single read cycle, stalls the pipeline until the word returns,
// holds the word while IF/ID is stalled by others, and aborts on flush or on
// a bus timeout.
//   clk, rst        : core clock, asynchronous active-high reset
//   cpu_ce_i/addr_i : fetch enable and PC
//   stall_i, flush_i: pipeline control from ctrl (stall_i[1] = IF/ID held)
//   cpu_data_o      : instruction word to if_id (combinational)
//   stallreq_o      : stall request to ctrl (combinational)
//   bus_err_o       : one-cycle pulse after a timeout abort
//   wb              : Wishbone master port
module inst_wb_bus_if #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [5:0]        stall_i,
    input  logic              flush_i,
    output logic [31:0]       cpu_data_o,
    output logic              stallreq_o,
    output logic              bus_err_o,
    inst_wb_bus_if_if.master  wb
);

    localparam int unsigned TMO_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [31:0]      adr_q,     adr_d;
    logic [3:0]       sel_q,     sel_d;
    logic             cyc_q,     cyc_d;
    logic [31:0]      rd_buf_q,  rd_buf_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             bus_err_q, bus_err_d;
    logic             tmo_hit;

    // Only the IF/ID bit of the stall vector matters here.
    logic unused_stall;
    assign unused_stall = ^{stall_i[5:2], stall_i[0]};

    // Last permitted BUSY cycle without an ack; TIMEOUT of 0 never fires.
    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

    // Next-state and combinational fetch-side outputs.
    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        sel_d      = sel_q;
        cyc_d      = cyc_q;
        rd_buf_d   = rd_buf_q;
        tmo_cnt_d  = tmo_cnt_q;
        bus_err_d  = 1'b0;
        stallreq_o = 1'b0;
        cpu_data_o = 32'h0;

        case (state_q)
            ST_IDLE: begin
                stallreq_o = cpu_ce_i & ~flush_i;
                if (cpu_ce_i && !flush_i) begin
                    adr_d     = cpu_addr_i;
                    sel_d     = 4'hF;
                    cyc_d     = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (wb.wb_ack_i) begin
                    // Ack wins over timeout; a coincident flush discards the word.
                    cyc_d = 1'b0;
                    sel_d = 4'h0;
                    if (flush_i) begin
                        rd_buf_d = 32'h0;
                        state_d  = ST_IDLE;
                    end else begin
                        rd_buf_d   = wb.wb_dat_i;
                        cpu_data_o = wb.wb_dat_i;
                        state_d    = stall_i[1] ? ST_WAIT : ST_IDLE;
                    end
                end else if (flush_i || tmo_hit) begin
                    cyc_d     = 1'b0;
                    sel_d     = 4'h0;
                    rd_buf_d  = 32'h0;
                    bus_err_d = ~flush_i;
                    state_d   = ST_IDLE;
                end else begin
                    stallreq_o = 1'b1;
                    tmo_cnt_d  = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_WAIT: begin
                // Replay the captured word until IF/ID is released.
                cpu_data_o = rd_buf_q;
                if (flush_i) begin
                    rd_buf_d = 32'h0;
                    state_d  = ST_IDLE;
                end else if (!stall_i[1]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered bus outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            adr_q     <= 32'h0;
            sel_q     <= 4'h0;
            cyc_q     <= 1'b0;
            rd_buf_q  <= 32'h0;
            tmo_cnt_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            sel_q     <= sel_d;
            cyc_q     <= cyc_d;
            rd_buf_q  <= rd_buf_d;
            tmo_cnt_q <= tmo_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    // stb and cyc share one flop so they can never diverge; reads only.
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = 32'h0;
    assign wb.wb_we_o  = 1'b0;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_stb_o = cyc_q;
    assign wb.wb_cyc_o = cyc_q;
    assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_inst_wb_bus_if.sv
// Self-checking bench for inst_wb_bus_if: directed vector table, hand-written
// timeout / async-reset / back-to-back sequences, then randomized traffic
// against a cycle-level behavioural model.
module tb_inst_wb_bus_if;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        bus_err_o;

    inst_wb_bus_if_if wbi ();

    inst_wb_bus_if #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_addr_i (cpu_addr_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .bus_err_o  (bus_err_o),
        .wb         (wbi)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic        stall1;
        logic        flush;
        logic        ack;
        logic [31:0] dat;
        logic        e_req;
        logic [31:0] e_data;
        logic        e_cyc;
        logic [31:0] e_adr;
    } vec_t;

    vec_t tv[19];

    function automatic vec_t mk(input logic ce, input logic [31:0] addr, input logic st,
                                input logic fl, input logic ack, input logic [31:0] dat,
                                input logic e_req, input logic [31:0] e_data,
                                input logic e_cyc, input logic [31:0] e_adr);
        vec_t v;
        v.ce = ce; v.addr = addr; v.stall1 = st; v.flush = fl; v.ack = ack; v.dat = dat;
        v.e_req = e_req; v.e_data = e_data; v.e_cyc = e_cyc; v.e_adr = e_adr;
        return v;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ce, input logic [31:0] addr, input logic st,
                         input logic fl, input logic ack, input logic [31:0] dat);
        cpu_ce_i      = ce;
        cpu_addr_i    = addr;
        stall_i       = st ? 6'b000011 : 6'b000000;
        flush_i       = fl;
        wbi.wb_ack_i  = ack;
        wbi.wb_dat_i  = dat;
    endtask

    // Registered bus outputs; address only meaningful while a cycle is open.
    task automatic check_regs(input string tag, input logic e_cyc, input logic [31:0] e_adr,
                              input logic e_err);
        chk1({tag, ".cyc"}, wbi.wb_cyc_o, e_cyc);
        chk1({tag, ".stb"}, wbi.wb_stb_o, e_cyc);
        chk32({tag, ".sel"}, {28'h0, wbi.wb_sel_o}, e_cyc ? 32'hF : 32'h0);
        chk1({tag, ".err"}, bus_err_o, e_err);
        chk1({tag, ".we"}, wbi.wb_we_o, 1'b0);
        if (e_cyc) chk32({tag, ".adr"}, wbi.wb_adr_o, e_adr);
    endtask

    // Behavioural model state for the random phase.
    bit          m_busy, m_hold, m_err;
    int          m_wait;
    logic [31:0] m_adr, m_buf;

    initial begin
        int start[3];
        logic        r_ce, r_st, r_fl, r_ack;
        logic [31:0] r_addr, r_dat;
        logic        e_req;
        logic [31:0] e_data;
        bit          skip_data;

        //          ce addr          st fl ack dat            req data           cyc adr
        tv[0]  = mk(1, 32'h10,       0, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0);
        tv[1]  = mk(1, 32'h10,       0, 0, 0, 32'h0,          1, 32'h0,          1, 32'h10);
        tv[2]  = mk(1, 32'h10,       0, 0, 1, 32'h3401_1100,  0, 32'h3401_1100,  1, 32'h10);
        tv[3]  = mk(0, 32'h0,        0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0);
        tv[4]  = mk(1, 32'h20,       0, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0);
        tv[5]  = mk(1, 32'h20,       0, 0, 0, 32'h0,          1, 32'h0,          1, 32'h20);
        tv[6]  = mk(1, 32'h20,       0, 0, 0, 32'h0,          1, 32'h0,          1, 32'h20);
        tv[7]  = mk(1, 32'h20,       0, 0, 0, 32'h0,          1, 32'h0,          1, 32'h20);
        tv[8]  = mk(1, 32'h20,       0, 0, 0, 32'h0,          1, 32'h0,          1, 32'h20);
        tv[9]  = mk(1, 32'h20,       1, 0, 1, 32'hDEAD_BEEF,  0, 32'hDEAD_BEEF,  1, 32'h20);
        tv[10] = mk(1, 32'h20,       1, 0, 0, 32'h0,          0, 32'hDEAD_BEEF,  0, 32'h0);
        tv[11] = mk(1, 32'h20,       1, 0, 0, 32'h0,          0, 32'hDEAD_BEEF,  0, 32'h0);
        tv[12] = mk(1, 32'h20,       1, 0, 0, 32'h0,          0, 32'hDEAD_BEEF,  0, 32'h0);
        tv[13] = mk(1, 32'h20,       0, 0, 0, 32'h0,          0, 32'hDEAD_BEEF,  0, 32'h0);
        tv[14] = mk(0, 32'h0,        0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0);
        tv[15] = mk(1, 32'h30,       0, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0);
        tv[16] = mk(1, 32'h30,       0, 0, 0, 32'h0,          1, 32'h0,          1, 32'h30);
        tv[17] = mk(1, 32'h30,       0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h30);
        tv[18] = mk(0, 32'h0,        0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0);

        // Reset state.
        rst = 1'b1;
        drive(0, 32'h0, 0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst.req", stallreq_o, 1'b0);
        chk32("rst.data", cpu_data_o, 32'h0);
        chk32("rst.adr", wbi.wb_adr_o, 32'h0);
        check_regs("rst", 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors: zero-wait read, wait states + external stall, flush.
        for (int i = 0; i < 19; i++) begin
            drive(tv[i].ce, tv[i].addr, tv[i].stall1, tv[i].flush, tv[i].ack, tv[i].dat);
            @(negedge clk);
            chk1($sformatf("vec%0d.req", i), stallreq_o, tv[i].e_req);
            chk32($sformatf("vec%0d.data", i), cpu_data_o, tv[i].e_data);
            check_regs($sformatf("vec%0d", i), tv[i].e_cyc, tv[i].e_adr, 1'b0);
            @(posedge clk); #1;
        end

        // Timeout: no ack ever, cycle dropped after TMO busy cycles.
        drive(1, 32'h40, 0, 0, 0, 32'h0);
        @(negedge clk);
        chk1("tmo.issue", stallreq_o, 1'b1);
        @(posedge clk); #1;
        drive(0, 32'h0, 0, 0, 0, 32'h0);
        for (int k = 1; k <= int'(TMO); k++) begin
            @(negedge clk);
            chk1($sformatf("tmo%0d.req", k), stallreq_o, k < int'(TMO));
            chk32($sformatf("tmo%0d.data", k), cpu_data_o, 32'h0);
            check_regs($sformatf("tmo%0d", k), 1'b1, 32'h40, 1'b0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk32("tmo.end.data", cpu_data_o, 32'h0);
        check_regs("tmo.end", 1'b0, 32'h0, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("tmo.err_pulse_end", bus_err_o, 1'b0);
        @(posedge clk); #1;

        // Async reset in the middle of a BUSY cycle.
        drive(1, 32'h50, 0, 0, 0, 32'h0);
        @(posedge clk); #1;
        drive(0, 32'h0, 0, 0, 0, 32'h0);
        @(negedge clk);
        chk1("arst.pre_cyc", wbi.wb_cyc_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("arst.req", stallreq_o, 1'b0);
        chk32("arst.adr", wbi.wb_adr_o, 32'h0);
        check_regs("arst", 1'b0, 32'h0, 1'b0);
        @(posedge clk); #3 rst = 1'b0;
        @(negedge clk);
        check_regs("arst.post", 1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;

        // Back-to-back zero-wait fetches at 0x0, 0x4, 0x8.
        for (int f = 0; f < 3; f++) begin
            logic [31:0] a, d;
            a = 32'(4 * f);
            d = 32'hA5A5_0000 + 32'(f);
            drive(1, a, 0, 0, 0, 32'h0);
            @(negedge clk);
            chk1($sformatf("b2b%0d.req0", f), stallreq_o, 1'b1);
            @(posedge clk); #1;
            @(negedge clk);
            start[f] = cyc_n;
            chk1($sformatf("b2b%0d.req1", f), stallreq_o, 1'b1);
            check_regs($sformatf("b2b%0d", f), 1'b1, a, 1'b0);
            @(posedge clk); #1;
            drive(1, a, 0, 0, 1, d);
            @(negedge clk);
            chk32($sformatf("b2b%0d.data", f), cpu_data_o, d);
            chk1($sformatf("b2b%0d.req2", f), stallreq_o, 1'b0);
            @(posedge clk); #1;
        end
        chk32("b2b.gap01", 32'(start[1] - start[0]), 32'd3);
        chk32("b2b.gap12", 32'(start[2] - start[1]), 32'd3);
        drive(0, 32'h0, 0, 0, 0, 32'h0);
        @(posedge clk); #1;

        // Randomized traffic against the behavioural model (starts idle).
        m_busy = 0; m_hold = 0; m_err = 0; m_wait = 0; m_adr = 32'h0; m_buf = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            r_ce   = 1'($urandom_range(0, 1));
            r_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            r_st   = ($urandom_range(0, 2) == 0);
            r_fl   = ($urandom_range(0, 11) == 0);
            r_ack  = m_busy && ($urandom_range(0, 3) == 0);
            r_dat  = $urandom;
            drive(r_ce, r_addr, r_st, r_fl, r_ack, r_dat);

            skip_data = 0;
            if (m_busy) begin
                if (r_ack) begin
                    e_req = 0; e_data = r_dat; skip_data = r_fl;
                end else if (r_fl || m_wait == int'(TMO) - 1) begin
                    e_req = 0; e_data = 32'h0;
                end else begin
                    e_req = 1; e_data = 32'h0;
                end
            end else if (m_hold) begin
                e_req = 0; e_data = m_buf;
            end else begin
                e_req = r_ce & ~r_fl; e_data = 32'h0;
            end

            @(negedge clk);
            chk1("rnd.req", stallreq_o, e_req);
            if (!skip_data) chk32("rnd.data", cpu_data_o, e_data);
            check_regs("rnd", m_busy, m_adr, m_err);
            @(posedge clk);

            m_err = 0;
            if (m_busy) begin
                if (r_ack) begin
                    m_busy = 0;
                    m_buf  = r_fl ? 32'h0 : r_dat;
                    m_hold = !r_fl && r_st;
                end else if (r_fl) begin
                    m_busy = 0;
                end else if (m_wait == int'(TMO) - 1) begin
                    m_busy = 0;
                    m_err  = 1;
                end else begin
                    m_wait++;
                end
            end else if (m_hold) begin
                if (r_fl || !r_st) m_hold = 0;
            end else if (r_ce && !r_fl) begin
                m_busy = 1;
                m_wait = 0;
                m_adr  = r_addr;
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
